write_buffer: RTL
=================

# write_buffer

- Posted-write FIFO between the write-through L1 data cache and the L2 cache.
- Absorbs L1 store traffic in one cycle and drains it to L2 in order through a valid/ready handshake.
- Lets the L1 read path forward pending store data so reads never see stale L2 contents.
- Decouples L1 write hits from L2 write occupancy.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 32, data word width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  L1 presents a write
- in_ready  output  1  buffer can accept a write
- in_address  input  ADDR_WIDTH  write address
- in_data  input  DATA_WIDTH  write data
- lookup_address  input  ADDR_WIDTH  L1 read address for forwarding check
- lookup_hit  output  1  a pending entry matches lookup_address
- lookup_data  output  DATA_WIDTH  data of youngest matching entry, 0 when no hit
- out_valid  output  1  head entry offered to L2
- out_ready  input  1  L2 accepts head entry
- out_address  output  ADDR_WIDTH  head entry address
- out_data  output  DATA_WIDTH  head entry data
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- Storage: DEPTH entries of {valid, address, data}, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a count register.
- Push: in_valid && in_ready at a rising edge writes the entry at tail, advances tail, and increments count.
- Pop: out_valid && out_ready at a rising edge clears the head entry, advances head, and decrements count.
- Simultaneous push and pop: both happen and count is unchanged.
- in_ready = !full, driven from registered state only. A push is refused while full, even if a pop occurs in the same cycle.
- out_valid = !empty. out_address/out_data come from the head entry and hold stable while out_valid && !out_ready.
- Forwarding:
  - lookup_hit/lookup_data are combinational over registered valid entries only.
  - A write being pushed in the same cycle is not visible until the next cycle.
  - With multiple matches, the youngest entry (closest to tail) wins.
  - An entry popped at an edge stops matching from the following cycle.
- Ordering: L2 sees writes in acceptance order, except where coalescing merges them (see Configuration).

## Timing
- Reset values: in_ready=1, out_valid=0, out_address=0, out_data=0, lookup_hit=0, lookup_data=0, count=0, empty=1, full=0. Pointers are 0 and all valid bits are cleared.
- Reset asserted mid-operation discards all pending entries immediately (asynchronous). The first push after deassertion lands in entry 0.
- Push-to-out_valid latency: 1 cycle from an empty buffer, with out_valid high the cycle after the accepting edge.
- Push-to-forward latency: 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- Wrap-around: with DEPTH=4, the 5th push after 1 pop uses entry 0, and count and full stay consistent.

## Configuration
- WRITE_BUFFER_COALESCE_EN defined:
  - A push whose address matches a valid entry other than the head overwrites that entry's data in place.
  - Count and tail are unchanged.
  - The push is accepted even when full, i.e. in_ready = !full || coalescing match.
  - A match only at the head allocates a new entry, because the head must stay stable while offered.
- WRITE_BUFFER_COALESCE_EN undefined: every accepted push allocates a new entry, and in_ready = !full.

## Test plan
- Reset then idle: all outputs equal the reset values. Push {0x20, 0xabcdef} with out_ready=0: next cycle out_valid=1, out_address=0x20, out_data=0xabcdef, count=1.
- Fill 4 entries (0x20, 0x28, 0x30, 0x38) with out_ready=0: full=1, in_ready=0. A 5th push of 0x40 is refused and data is held stable. Then out_ready=1 drains 0x20, 0x28, 0x30, 0x38 in order on consecutive cycles, ending empty=1.
- Forwarding: push {0x28, 0x12345}, then {0x28, 0x54321} without coalescing, lookup_address=0x28. Result: lookup_hit=1, lookup_data=0x54321. lookup_address=0x24 gives lookup_hit=0, lookup_data=0.
- Simultaneous push/pop at count=2 for 6 cycles: count stays 2, pointers wrap, and the outputs show the addresses in push order.
- Assert rst with count=3 mid-drain: the same cycle shows out_valid=0, count=0. After release, push 0x20 and it appears at the head.
- With WRITE_BUFFER_COALESCE_EN: push 0x20, 0x28, then {0x28, 0xdead}. count=2, and drain order is 0x20 then {0x28, 0xdead}.

Source files
------------

// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between a write-through L1 data cache and L2.
// L1 stores are taken in one cycle and drained to L2 in order via valid/ready.
// Pending stores are visible to the L1 read path through the lookup port, and
// the youngest matching entry supplies the forwarded data.
// Optional feature macro: WRITE_BUFFER_COALESCE_EN. When it is defined, a store
// to an address already pending in a non-head entry overwrites that entry in place.
module write_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ADDR_WIDTH-1:0]   lookup_address,
  output logic                    lookup_hit,
  output logic [DATA_WIDTH-1:0]   lookup_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_address,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage: valid bits are control and are reset; address/data are not.
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  coal_hit;
  logic [PTR_W-1:0]      coal_idx;
  logic                  push_alloc;
  logic                  push_coal;
  logic                  pop;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

`ifdef WRITE_BUFFER_COALESCE_EN
  // Find the youngest valid non-head entry whose address matches the incoming store.
  // The head is skipped because it is being offered to L2 and must stay stable.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == in_address)) begin
        coal_hit = 1'b1;
        coal_idx = head_q + PTR_W'(i);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  assign in_ready   = !full_w || coal_hit;
  assign push_coal  = in_valid && coal_hit;
  assign push_alloc = in_valid && !full_w && !coal_hit;
  assign pop        = !empty_w && out_ready;

  // Control state: valid bits, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push_alloc && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_alloc && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Entry payload: written on allocation at the tail, or in place on coalesce.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      addr_q[tail_q] <= in_address;
      data_q[tail_q] <= in_data;
    end
    if (push_coal) begin
      data_q[coal_idx] <= in_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (addr_q[head_q + PTR_W'(i)] == lookup_address)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[head_q + PTR_W'(i)];
      end
    end
  end

  // Head entry is presented only while occupied so outputs read zero when empty.
  assign out_valid   = !empty_w;
  assign out_address = out_valid ? addr_q[head_q] : '0;
  assign out_data    = out_valid ? data_q[head_q] : '0;
  assign count       = count_q;
  assign empty       = empty_w;
  assign full        = full_w;

endmodule
